// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and constants for the serial magnitude comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One-hot result encoding, bit order {lt, gt, eq}; RES_NONE = no decision yet
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b001;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b100;

    // Width of the bit index register; never narrower than one bit
    function automatic int idx_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// rtl/cmp_bit_cell.sv - combinational one-bit magnitude compare cell
module cmp_bit_cell (
    input  logic x_i,
    input  logic y_i,
    output logic bit_eq_o,
    output logic bit_gt_o,
    output logic bit_lt_o
);

    // Single-bit relation of x against y
    always_comb begin
        bit_eq_o = ~(x_i ^ y_i);
        bit_gt_o = x_i & ~y_i;
        bit_lt_o = ~x_i & y_i;
    end

endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// rtl/serial_mag_comp_ctrl.sv - MSB-first bit-serial magnitude comparator controller
module serial_mag_comp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int             IW      = idx_width(WIDTH);
    localparam logic [IW-1:0]  IDX_MSB = IW'(WIDTH - 1);

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [IW-1:0]     idx_q;
    logic [2:0]        res_q;
    logic [2:0]        res_d;
    logic              busy_q;
    logic              done_q;
    logic              eq_q;
    logic              gt_q;
    logic              lt_q;

    logic              cell_eq;
    logic              cell_gt;
    logic              cell_lt;
    logic              mismatch;
    logic              last_bit;

    cmp_bit_cell u_cell (
        .x_i      (a_q[idx_q]),
        .y_i      (b_q[idx_q]),
        .bit_eq_o (cell_eq),
        .bit_gt_o (cell_gt),
        .bit_lt_o (cell_lt)
    );

    // Result after the current bit: the first mismatch wins, equality only after bit 0
    always_comb begin
        mismatch = ~cell_eq;
        last_bit = (idx_q == '0);
        res_d    = res_q;
        if (res_q == RES_NONE) begin
            if (cell_gt) begin
                res_d = RES_GT;
            end else if (cell_lt) begin
                res_d = RES_LT;
            end else if (last_bit) begin
                res_d = RES_EQ;
            end
        end
    end

    // Controller FSM; visible outputs are registered one cycle behind the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            res_q   <= RES_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    // busy_q is still high in the cycle that shows done
                    if (start && !busy_q) begin
                        a_q     <= a;
                        b_q     <= b;
                        idx_q   <= IDX_MSB;
                        res_q   <= RES_NONE;
                        eq_q    <= 1'b0;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    if ((EARLY_EXIT && mismatch) || last_bit) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    done_q                <= 1'b1;
                    {lt_q, gt_q, eq_q}    <= res_q;
                    state_q               <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// tb/tb_serial_mag_comp_ctrl.sv - scoreboard bench for serial_mag_comp_ctrl
module tb_serial_mag_comp_ctrl;

    typedef struct {
        logic [2:0] res;
        int         acc;
        int         n;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start0, start1;
    logic [7:0] a0, b0, a1, b1;
    logic       busy0, done0, eq0, gt0, lt0;
    logic       busy1, done1, eq1, gt1, lt1;

    int   cyc   = 0;
    int   ncmp  = 0;
    int   nfail = 0;
    exp_t q0[$];
    exp_t q1[$];

    int bc0 = 0, bc1 = 0;
    bit viol0 = 0, viol1 = 0;
    bit pd0 = 0, pd1 = 0;

    serial_mag_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .lt(lt0)
    );

    serial_mag_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        ncmp++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic mon_done(input int sel, input logic [2:0] res, input int bc,
                            input bit viol, input bit pd);
        exp_t e;
        bit   have;
        have = (sel == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
            ncmp++;
            nfail++;
            $display("FAIL unexpected_done dut%0d: got done with empty scoreboard, expected none", sel);
            return;
        end
        e = (sel == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("result{lt,gt,eq} dut%0d", sel), int'(res), int'(e.res));
        check($sformatf("latency dut%0d", sel), cyc - e.acc, e.n + 1);
        check($sformatf("busy_cycles dut%0d", sel), bc, e.n + 1);
        check($sformatf("results_zero_while_busy dut%0d", sel), int'(viol), 0);
        check($sformatf("done_single_pulse dut%0d", sel), int'(pd), 0);
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents done
    always @(negedge clk) begin
        if (!rst_n) begin
            bc0 = 0; bc1 = 0; viol0 = 0; viol1 = 0; pd0 = 0; pd1 = 0;
        end else begin
            if (busy0) bc0++;
            if (busy1) bc1++;
            if (busy0 && !done0 && (eq0 | gt0 | lt0)) viol0 = 1;
            if (busy1 && !done1 && (eq1 | gt1 | lt1)) viol1 = 1;
            if (done0) begin
                mon_done(0, {lt0, gt0, eq0}, bc0, viol0, pd0);
                bc0 = 0; viol0 = 0;
            end
            if (done1) begin
                mon_done(1, {lt1, gt1, eq1}, bc1, viol1, pd1);
                bc1 = 0; viol1 = 0;
            end
            pd0 = done0;
            pd1 = done1;
        end
    end

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    task automatic issue(input int sel, input logic [7:0] av, input logic [7:0] bv,
                         input logic [2:0] res, input int n, input bit wiggle);
        exp_t e;
        int   t;
        @(negedge clk);
        t = 0;
        while (busy_of(sel) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (sel == 0) begin start0 = 1'b1; a0 = av; b0 = bv; end
        else          begin start1 = 1'b1; a1 = av; b1 = bv; end
        @(posedge clk);
        #1;
        e.res = res; e.acc = cyc; e.n = n;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        if (sel == 0) start0 = 1'b0; else start1 = 1'b0;
        t = 0;
        while (!done_of(sel) && t < 50) begin
            if (wiggle) begin
                a0 = 8'($urandom); b0 = 8'($urandom);
            end
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            ncmp++;
            nfail++;
            $display("FAIL done_timeout dut%0d: no done within 50 cycles, expected done", sel);
        end
    endtask

    localparam logic [2:0] R_EQ = 3'b001;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b100;

    initial begin
        exp_t e;
        int   acc;
        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset outs dut0 {busy,done,eq,gt,lt}", int'({busy0, done0, eq0, gt0, lt0}), 0);
        check("reset outs dut1 {busy,done,eq,gt,lt}", int'({busy1, done1, eq1, gt1, lt1}), 0);

        // Early-exit DUT: equal, MSB mismatch, LSB mismatch
        issue(0, 8'h5A, 8'h5A, R_EQ, 8, 1'b0);
        issue(0, 8'h80, 8'h7F, R_GT, 1, 1'b0);
        issue(0, 8'h12, 8'h13, R_LT, 8, 1'b0);

        // Full-scan DUT: only the most significant mismatch decides
        issue(1, 8'h80, 8'h7F, R_GT, 8, 1'b0);
        issue(1, 8'h12, 8'h13, R_LT, 8, 1'b0);
        issue(1, 8'h5A, 8'h5A, R_EQ, 8, 1'b0);

        // start held high: one accept every 10 edges (N=7, done, busy tail, accept)
        @(negedge clk);
        while (busy0) @(negedge clk);
        start0 = 1'b1; a0 = 8'h01; b0 = 8'h02;
        @(posedge clk);
        #1;
        acc = cyc;
        for (int i = 0; i < 3; i++) begin
            e.res = R_LT; e.acc = acc + 10 * i; e.n = 7;
            q0.push_back(e);
        end
        while (cyc < acc + 29) @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        check("held_start dut0 accepts drained", q0.size(), 0);

        // Asynchronous reset mid-RUN at idx=4: no done may follow
        @(negedge clk);
        start0 = 1'b1; a0 = 8'h5A; b0 = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outs dut0 {busy,done,eq,gt,lt}", int'({busy0, done0, eq0, gt0, lt0}), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post reset busy dut0", int'(busy0), 0);
        issue(0, 8'hFF, 8'h00, R_GT, 1, 1'b0);

        // Operands wiggle during RUN: latched 3C vs 3A decides at bit 2
        issue(0, 8'h3C, 8'h3A, R_GT, 6, 1'b1);

        repeat (5) @(negedge clk);
        check("scoreboard dut0 empty", q0.size(), 0);
        check("scoreboard dut1 empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/serial_mag_comp_ctrl.md
Name: serial_mag_comp_ctrl

Overview:
Bit-serial magnitude comparator controller. It latches two WIDTH-bit operands on a start handshake and steps a single 1-bit compare cell through them MSB-first, one bit per clock. It stops at the first differing bit and reports equal, greater or less with a one-cycle done pulse. It provides multi-bit compare for the comparator family at a cost of one bit-cell plus a small FSM, in place of a WIDTH-wide parallel tree.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
EARLY_EXIT, 1, 1 = terminate at the first mismatching bit; 0 = always scan all WIDTH bits.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a compare; sampled only in IDLE.
a  input  WIDTH  operand A (unsigned); sampled on the accepting edge.
b  input  WIDTH  operand B (unsigned); sampled on the accepting edge.
busy  output  1  high in RUN and DONE.
done  output  1  single-cycle pulse; results valid from this cycle on.
eq  output  1  A == B.
gt  output  1  A > B.
lt  output  1  A < B.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, eq, gt, lt all 0; operand registers and bit index cleared. Reset mid-RUN aborts the compare with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches a and b, sets idx=WIDTH-1, clears eq/gt/lt to 0, and enters RUN. start=0 stays in IDLE.
- RUN, each cycle: the compare cell evaluates A[idx] against B[idx].
  - A[idx]=1, B[idx]=0: record gt. A[idx]=0, B[idx]=1: record lt.
  - If EARLY_EXIT=1 and a mismatch is found, the next state is DONE.
  - Otherwise, if idx==0, the next state is DONE. With no mismatch recorded, eq is set.
  - Otherwise idx decrements.
- With EARLY_EXIT=0, only the first (most significant) mismatch decides the result; later bits are ignored.
- DONE: done=1 for exactly one cycle; eq/gt/lt are already valid in this cycle. The next state is IDLE unconditionally.
- start is ignored while busy=1, including in the DONE cycle. No queuing.
- Results hold in IDLE until the next accepted start clears them. After any done, exactly one of eq/gt/lt is 1. Before any done, and while busy, all three are 0.
- Latency:
  - N = number of bits examined. N=WIDTH when EARLY_EXIT=0 or A==B; otherwise N = (WIDTH-1-k)+1, where k is the index of the most significant differing bit.
  - done is asserted in the cycle following the (N+1)th edge after the accepting edge.
  - Minimum N=1 (MSB differs), maximum N=WIDTH.
- Operands change freely on a/b after acceptance; the latched copies are used.
- No arithmetic beyond the idx decrement. The idx width is clog2(WIDTH) and it never wraps below 0.

Decomposition:
- Package cmp_pkg:
  - state enum {IDLE, RUN, DONE};
  - result encoding constants (RES_EQ, RES_GT, RES_LT as one-hot 3-bit);
  - function for idx width.
- Sub-module cmp_bit_cell: purely combinational, inputs x and y, outputs bit_eq, bit_gt, bit_lt. It is instantiated once; the controller owns all state.

Test Plan:
- WIDTH=8, EARLY_EXIT=1, start with a=8'h5A, b=8'h5A -> done in the cycle after edge 9 post-accept; eq=1, gt=0, lt=0; busy high for 9 cycles.
- a=8'h80, b=8'h7F -> N=1, done after 2 edges; gt=1. Then a=8'h12, b=8'h13 -> N=8; lt=1.
- EARLY_EXIT=0, a=8'h80, b=8'h7F -> done after 9 edges; gt=1 (later bits where B>A are ignored).
- start held high continuously with a=1, b=2 -> one accept per IDLE visit; start in RUN and DONE cycles is ignored; each done is a single-cycle pulse with lt=1.
- Assert rst_n low asynchronously mid-RUN (idx=4) -> all outputs 0 immediately with no done. After release, a fresh start with a=8'hFF, b=8'h00 -> gt after N=1.
- Change a/b on every cycle during RUN -> the result reflects the latched operands only.
